// File: rtl/clock_display.sv
// Time-of-day display back-end: syncs ripple-counter sec/min/hr, converts to BCD, drives six active-low 7-seg digits.
// Latency: 13 clk from a stable input change to HEX update (3 sync, accept, load, 6 shift, store, output reg).
// Backpressure: none; inputs are sampled continuously and a change during a conversion is reconverted afterwards.
module clock_display #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    input  logic       set_mode,
    input  logic       mode_12h,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic       pm,
    output logic       valid
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] STORE = 2'd3;

    localparam int             CW         = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]  BLINK_LAST = CW'(BLINK_DIV - 1);
    localparam logic [6:0]     BLANK      = 7'b1111111;

    // synchronizer stages
    logic [5:0] sec_s1, sec_s2, sec_s3;
    logic [5:0] min_s1, min_s2, min_s3;
    logic [4:0] hr_s1, hr_s2, hr_s3;
    logic       set_s1, set_s2;
    logic [1:0] fill_cnt;

    // conversion datapath
    logic [1:0] state;
    logic [5:0] cand_sec, cand_min;
    logic [4:0] cand_hr;
    logic       cand_12h;
    logic [5:0] bin_sec, bin_min, bin_hr;
    logic [7:0] bcd_sec, bcd_min, bcd_hr;
    logic [2:0] bit_cnt;
    logic       pm_next;

    // stored result
    logic [7:0] dig_sec, dig_min, dig_hr;
    logic [5:0] snap_sec, snap_min;
    logic [4:0] snap_hr;
    logic       snap_12h;
    logic       pm_r;
    logic       valid_r;

    // blink
    logic [CW-1:0] blink_cnt;
    logic          blink_on;

    logic       accept;
    logic       changed;
    logic [4:0] hr_conv;
    logic       pm_calc;

    // One double-dabble step on a two-nibble BCD value: add 3 to nibbles >=5, then shift in msb.
    function automatic logic [7:0] dabble(input logic [7:0] b, input logic msb);
        logic [7:0] t;
        t = b;
        if (t[3:0] >= 4'd5) t[3:0] = t[3:0] + 4'd3;
        if (t[7:4] >= 4'd5) t[7:4] = t[7:4] + 4'd3;
        return {t[6:0], msb};
    endfunction

    // Active-low {g,f,e,d,c,b,a} decode; anything above 9 shows blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    // The sync pipeline holds reset zeros until three clocks have passed, so fill_cnt gates acceptance.
    assign accept  = (fill_cnt == 2'd3) && (sec_s2 == sec_s3) && (min_s2 == min_s3) && (hr_s2 == hr_s3);
    assign changed = (sec_s3 != snap_sec) || (min_s3 != snap_min) || (hr_s3 != snap_hr) ||
                     (mode_12h != snap_12h) || !valid_r;
    assign valid   = valid_r;

    // 12-hour mapping: 0 -> 12, 1..12 as-is, 13..31 -> hr-12.
    always_comb begin
        hr_conv = cand_hr;
        pm_calc = cand_12h && (cand_hr >= 5'd12);
        if (cand_12h) begin
            if (cand_hr == 5'd0)       hr_conv = 5'd12;
            else if (cand_hr > 5'd12)  hr_conv = cand_hr - 5'd12;
        end
    end

    // Input synchronizers plus the third stage used to reject mid-ripple samples.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sec_s1 <= '0; sec_s2 <= '0; sec_s3 <= '0;
            min_s1 <= '0; min_s2 <= '0; min_s3 <= '0;
            hr_s1  <= '0; hr_s2  <= '0; hr_s3  <= '0;
            set_s1 <= 1'b0; set_s2 <= 1'b0;
            fill_cnt <= 2'd0;
        end else begin
            sec_s1 <= sec; sec_s2 <= sec_s1; sec_s3 <= sec_s2;
            min_s1 <= min; min_s2 <= min_s1; min_s3 <= min_s2;
            hr_s1  <= hr;  hr_s2  <= hr_s1;  hr_s3  <= hr_s2;
            set_s1 <= set_mode; set_s2 <= set_s1;
            if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
        end
    end

    // Conversion FSM: accept a stable sample, run 6 shift-add-3 steps on all fields, store digits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cand_sec <= '0; cand_min <= '0; cand_hr <= '0; cand_12h <= 1'b0;
            bin_sec  <= '0; bin_min  <= '0; bin_hr  <= '0;
            bcd_sec  <= '0; bcd_min  <= '0; bcd_hr  <= '0;
            bit_cnt  <= 3'd0;
            pm_next  <= 1'b0;
            dig_sec  <= '0; dig_min  <= '0; dig_hr  <= '0;
            snap_sec <= '0; snap_min <= '0; snap_hr <= '0; snap_12h <= 1'b0;
            pm_r     <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && changed) begin
                        cand_sec <= sec_s3;
                        cand_min <= min_s3;
                        cand_hr  <= hr_s3;
                        cand_12h <= mode_12h;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    bin_sec <= cand_sec;
                    bin_min <= cand_min;
                    bin_hr  <= {1'b0, hr_conv};
                    pm_next <= pm_calc;
                    bcd_sec <= '0;
                    bcd_min <= '0;
                    bcd_hr  <= '0;
                    bit_cnt <= 3'd6;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    bcd_sec <= dabble(bcd_sec, bin_sec[5]);
                    bcd_min <= dabble(bcd_min, bin_min[5]);
                    bcd_hr  <= dabble(bcd_hr,  bin_hr[5]);
                    bin_sec <= {bin_sec[4:0], 1'b0};
                    bin_min <= {bin_min[4:0], 1'b0};
                    bin_hr  <= {bin_hr[4:0],  1'b0};
                    bit_cnt <= bit_cnt - 3'd1;
                    if (bit_cnt == 3'd1) state <= STORE;
                end
                STORE: begin
                    dig_sec  <= bcd_sec;
                    dig_min  <= bcd_min;
                    dig_hr   <= bcd_hr;
                    pm_r     <= pm_next;
                    snap_sec <= cand_sec;
                    snap_min <= cand_min;
                    snap_hr  <= cand_hr;
                    snap_12h <= cand_12h;
                    valid_r  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Blink generator: held ON outside set mode, otherwise toggles every BLINK_DIV cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!set_s2) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Registered segment outputs with blanking: invalid > blink-off > 12h leading zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            HEX0 <= BLANK; HEX1 <= BLANK; HEX2 <= BLANK;
            HEX3 <= BLANK; HEX4 <= BLANK; HEX5 <= BLANK;
            pm   <= 1'b0;
        end else begin
            HEX0 <= valid_r ? seg7(dig_sec[3:0]) : BLANK;
            HEX1 <= valid_r ? seg7(dig_sec[7:4]) : BLANK;
            HEX2 <= (valid_r && blink_on) ? seg7(dig_min[3:0]) : BLANK;
            HEX3 <= (valid_r && blink_on) ? seg7(dig_min[7:4]) : BLANK;
            HEX4 <= (valid_r && blink_on) ? seg7(dig_hr[3:0])  : BLANK;
            HEX5 <= (valid_r && blink_on && !(snap_12h && dig_hr[7:4] == 4'd0)) ?
                    seg7(dig_hr[7:4]) : BLANK;
            pm   <= pm_r;
        end
    end

endmodule

// File: tb/tb_clock_display.sv
// Directed bench for clock_display with a short blink period.
module tb_clock_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic       set_mode, mode_12h;
    logic [6:0] h0, h1, h2, h3, h4, h5;
    logic       pm, valid;

    int total = 0;
    int bad   = 0;
    logic glitch;

    localparam logic [6:0] BL = 7'b1111111;

    clock_display #(.BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr),
        .set_mode(set_mode), .mode_12h(mode_12h),
        .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5),
        .pm(pm), .valid(valid)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] sg(input int d);
        case (d)
            0: sg = 7'b1000000;
            1: sg = 7'b1111001;
            2: sg = 7'b0100100;
            3: sg = 7'b0110000;
            4: sg = 7'b0011001;
            5: sg = 7'b0010010;
            6: sg = 7'b0000010;
            7: sg = 7'b1111000;
            8: sg = 7'b0000000;
            9: sg = 7'b0010000;
            default: sg = 7'b1111111;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                           input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, ".HEX5"}, h5, e5);
        chk({tag, ".HEX4"}, h4, e4);
        chk({tag, ".HEX3"}, h3, e3);
        chk({tag, ".HEX2"}, h2, e2);
        chk({tag, ".HEX1"}, h1, e1);
        chk({tag, ".HEX0"}, h0, e0);
    endtask

    initial begin
        rst = 1'b0; sec = 6'd5; min = 6'd7; hr = 5'd9;
        set_mode = 1'b0; mode_12h = 1'b0; glitch = 1'b0;

        // reset, then first conversion
        tick(1);
        chk_all("reset", BL, BL, BL, BL, BL, BL);
        chk("reset.valid", {6'b0, valid}, 7'd0);
        chk("reset.pm", {6'b0, pm}, 7'd0);
        tick(2);
        rst = 1'b1;
        tick(12);
        chk("first.not_yet", h0, BL);
        tick(1);
        chk_all("first", sg(0), sg(9), sg(0), sg(7), sg(0), sg(5));
        chk("first.valid", {6'b0, valid}, 7'd1);

        // 24-hour boundaries
        sec = 6'd59; min = 6'd59; hr = 5'd23;
        tick(14);
        chk_all("max24", sg(2), sg(3), sg(5), sg(9), sg(5), sg(9));
        chk("max24.pm", {6'b0, pm}, 7'd0);
        sec = 6'd0; min = 6'd0; hr = 5'd0;
        tick(14);
        chk_all("zero24", sg(0), sg(0), sg(0), sg(0), sg(0), sg(0));

        // 12-hour mode
        mode_12h = 1'b1;
        tick(14);
        chk_all("h12_0", sg(1), sg(2), sg(0), sg(0), sg(0), sg(0));
        chk("h12_0.pm", {6'b0, pm}, 7'd0);
        hr = 5'd13;
        tick(14);
        chk("h12_13.HEX5", h5, BL);
        chk("h12_13.HEX4", h4, sg(1));
        chk("h12_13.pm", {6'b0, pm}, 7'd1);
        hr = 5'd12;
        tick(14);
        chk("h12_12.HEX5", h5, sg(1));
        chk("h12_12.HEX4", h4, sg(2));
        chk("h12_12.pm", {6'b0, pm}, 7'd1);
        hr = 5'd13;
        tick(14);
        mode_12h = 1'b0;
        tick(12);
        chk("to24.HEX5", h5, sg(1));
        chk("to24.HEX4", h4, sg(3));
        chk("to24.pm", {6'b0, pm}, 7'd0);

        // blink in set mode
        sec = 6'd0; min = 6'd30; hr = 5'd10;
        tick(14);
        chk_all("preblink", sg(1), sg(0), sg(3), sg(0), sg(0), sg(0));
        set_mode = 1'b1;
        tick(6);
        chk("blink.k6.HEX3", h3, sg(3));
        tick(1);
        chk_all("blink.k7", BL, BL, BL, BL, sg(0), sg(0));
        tick(3);
        chk("blink.k10.HEX2", h2, BL);
        chk("blink.k10.HEX0", h0, sg(0));
        tick(1);
        chk_all("blink.k11", sg(1), sg(0), sg(3), sg(0), sg(0), sg(0));
        tick(3);
        chk("blink.k14.HEX3", h3, sg(3));
        set_mode = 1'b0;
        tick(1);
        chk("blink.k15.HEX5", h5, BL);
        chk("blink.k15.HEX1", h1, sg(0));
        tick(2);
        chk("blink.k17.HEX4", h4, BL);
        tick(1);
        chk_all("unblink.k18", sg(1), sg(0), sg(3), sg(0), sg(0), sg(0));
        tick(8);
        chk_all("unblink.k26", sg(1), sg(0), sg(3), sg(0), sg(0), sg(0));

        // glitch rejection: 31, 32 held one cycle each, then 33 stable
        sec = 6'd31; tick(1);
        sec = 6'd32; tick(1);
        sec = 6'd33;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if ((h0 !== sg(0) && h0 !== sg(3)) || (h1 !== sg(0) && h1 !== sg(3))) glitch = 1'b1;
        end
        chk("glitch.seen", {6'b0, glitch}, 7'd0);
        chk("glitch.HEX1", h1, sg(3));
        chk("glitch.HEX0", h0, sg(3));

        // overlapping change during SHIFT
        min = 6'd45;
        tick(6);
        min = 6'd12;
        tick(7);
        chk("overlap.first.HEX3", h3, sg(4));
        chk("overlap.first.HEX2", h2, sg(5));
        tick(10);
        chk("overlap.final.HEX3", h3, sg(1));
        chk("overlap.final.HEX2", h2, sg(2));

        // reset during SHIFT
        sec = 6'd17;
        tick(6);
        rst = 1'b0;
        tick(1);
        chk("midrst.HEX0", h0, BL);
        chk("midrst.HEX5", h5, BL);
        chk("midrst.valid", {6'b0, valid}, 7'd0);
        tick(1);
        rst = 1'b1;
        tick(12);
        chk("midrst.not_yet", h0, BL);
        tick(1);
        chk_all("midrst.final", sg(1), sg(0), sg(1), sg(2), sg(1), sg(7));
        chk("midrst.valid_after", {6'b0, valid}, 7'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_display.md
# clock_display

Display back-end for the 24-hour time-of-day counter. It samples the binary `sec`/`min`/`hr` outputs of the counter, which are driven by ripple-clocked flops, into the `clk` domain. It converts them to BCD with an iterative shift-add-3 engine and drives six active-low 7-segment digits. In set mode it blinks the hour and minute digits, and it supports a 12-hour presentation with a PM flag.

## Interface
- `BLINK_DIV`, default 25_000_000: blink half-period in `clk` cycles (1 Hz blink at 50 MHz); legal range ≥2.
- `clk  in  1`: system clock.
- `rst  in  1`: reset, synchronous, active-low.
- `sec  in  6`: binary seconds from the time counter, asynchronous to `clk`.
- `min  in  6`: binary minutes, asynchronous.
- `hr  in  5`: binary hours, asynchronous.
- `set_mode  in  1`: 1 = time counter in set mode, asynchronous.
- `mode_12h  in  1`: 1 = 12-hour presentation, 0 = 24-hour presentation.
- `HEX0..HEX5  out  7 each`: segments `{g,f,e,d,c,b,a}`, active-low. HEX0/1 = sec ones/tens, HEX2/3 = min ones/tens, HEX4/5 = hr ones/tens.
- `pm  out  1`: 1 when the hour field shown is ≥12 in 12-hour mode; 0 in 24-hour mode.
- `valid  out  1`: 1 once the first conversion has been stored.

## Operation
- **Input sync:** `sec`, `min`, `hr` and `set_mode` pass through 2-flop synchronizers (s1, s2) plus a third register s3 for the value inputs.
  - A sample is accepted only when s2 == s3 for all three fields; this rejects mid-ripple values.
- **FSM states:** IDLE, LOAD, SHIFT, STORE.
  - IDLE → LOAD when the sample is accepted and either (a) it differs from the last stored snapshot, (b) `mode_12h` differs from the value used for the last conversion, or (c) `valid` = 0. Otherwise remain in IDLE.
  - LOAD: capture snapshot and `mode_12h`. Compute the hour to convert:
    - 24-hour mode: hr unchanged.
    - 12-hour mode: 0 → 12; 1–12 unchanged; 13–31 → hr−12.
    - Compute pm_next = `mode_12h` & (hr ≥ 12).
    - Clear the BCD scratch registers and set the bit counter to 6.
  - SHIFT: 6 cycles. The three fields convert in parallel, hour zero-extended to 6 bits. Each cycle, add 3 to any BCD nibble ≥5, then shift left 1, bringing in the field MSB. Exit to STORE when the counter reaches 0.
  - STORE: write six BCD digits, pm_next and the snapshot; set `valid`; return to IDLE.
- **Width rules:**
  - 6-bit inputs up to 63 convert correctly to two digits (tens ≤6). Out-of-range values are displayed as-is, not clamped.
  - Hour tens digit ≤3.
- **Segment decode:**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Blank = 1111111.
- **Blanking priority, highest first:**
  1. `valid` = 0 blanks all digits.
  2. Blink-off phase blanks HEX2–HEX5.
  3. In 12-hour mode, an hour tens digit of 0 blanks HEX5.
  - In 24-hour mode, a leading zero is shown.
  - Seconds digits never blink.
- **Blink:**
  - While synchronized `set_mode` = 0, the blink counter is held at 0 and the phase is ON (visible).
  - While `set_mode` = 1, the counter runs 0..BLINK_DIV−1. At wrap, the phase toggles and the counter returns to 0.
  - The first OFF phase starts BLINK_DIV cycles after `set_mode` is seen high.
  - Dropping `set_mode` forces the phase to ON on the next cycle.

## Timing
- **Reset values (cycle after `rst` = 0 sampled):**
  - FSM = IDLE.
  - `HEX0..HEX5` = 1111111.
  - `pm` = 0, `valid` = 0.
  - Digits and snapshot = 0; blink counter = 0, phase ON; synchronizers = 0.
- **Reset mid-operation:** reset in any state aborts the conversion; no partial digits reach the outputs.
- **Outputs:** `HEX*` and `pm` are registered and update the cycle after STORE.
- **Latency from stable input to HEX change:** 3 sync cycles + 1 IDLE accept + 1 LOAD + 6 SHIFT + 1 STORE + 1 output register = 13 `clk` cycles.
- **Overlapping input changes:** an input change during SHIFT/STORE is not lost. It is reconverted on the next IDLE, because it differs from the stored snapshot.
- **Blink timing:** the blink-phase change reaches `HEX2..HEX5` one cycle after the toggle, independent of the FSM.

## Test plan
- **Reset, then first conversion:** hold `rst` = 0 for 3 cycles with sec = 5, min = 7, hr = 9, `mode_12h` = 0.
  - During reset: all HEX = 1111111, `valid` = 0.
  - 13 cycles after release: HEX5..HEX0 = 0,9,0,7,0,5 and `valid` = 1.
- **Boundary values (24-hour):** sec = 59, min = 59, hr = 23 → HEX = 2,3,5,9,5,9 and `pm` = 0. Then sec = 0, min = 0, hr = 0 → 0,0,0,0,0,0.
- **12-hour mode:**
  - hr = 0 → hour 12, `pm` = 0.
  - hr = 13 → HEX5 blank, HEX4 = 1, `pm` = 1.
  - hr = 12 → 12, `pm` = 1.
  - Toggling `mode_12h` with hr = 13 fixed reconverts within 12 cycles to 1,3 and `pm` = 0.
- **Blink (BLINK_DIV = 4):** `set_mode` = 1 with min = 30, hr = 10.
  - HEX2–HEX5 alternate visible/blank every 4 cycles; HEX0/1 are never blank.
  - Drop `set_mode`: digits are visible within 4 cycles (synchronizer plus output register) and stay visible.
- **Glitch rejection and overlap:**
  - sec changes on consecutive cycles (e.g. 31, 32, 33 each held 1 cycle, then 33 stable): only stable values are accepted, and the final display is 33.
  - Changing min during SHIFT yields a second conversion; the final HEX equals the last stable input.
- **Mid-conversion reset:** assert `rst` = 0 during SHIFT → outputs blank and `valid` = 0 next cycle. After release, a full reconversion produces the correct digits.
